// File: rtl/sc_bitstream_gen.sv
// sc_bitstream_gen
//
// Stochastic-computing bitstream generator. Accepts an unsigned source value
// and a stream length over a valid/ready handshake, steps an external Sobol
// RNG in Gray-code order (rng_en_o / rng_idx_o) and emits one unipolar bit
// per transfer: bit_out_o = (src > rng_val_i). Downstream backpressure via
// out_ready_i stalls the stream without advancing the RNG.
//
// Optional feature macro: SC_BSGEN_ONES_CNT_EN
//   defined   -> ones_cnt_o counts 1 bits of the current/last stream
//   undefined -> no counter register, ones_cnt_o tied to 0
//
// Ports:
//   clk_i        clock
//   rst_n_i      synchronous active-low reset
//   in_valid_i   source request valid
//   in_ready_o   block can accept a request (IDLE only)
//   in_data_i    unsigned source value
//   in_len_i     stream length in bits, 0..2^RWID
//   rng_en_o     RNG enable, high only on transfer cycles
//   rng_idx_o    RNG direction-vector index (least-significant 0 of seq)
//   rng_val_i    current RNG output
//   bit_valid_o  bit_out_o is valid (RUN)
//   out_ready_i  consumer accepts a bit
//   bit_out_o    stochastic bit
//   done_o       one-cycle pulse when a stream completes
//   ones_cnt_o   number of 1 bits emitted in the current or last stream
//
// state | meaning
// IDLE  | waiting for a request, in_ready_o high
// RUN   | emitting bits, one per accepted transfer
// DONE  | one-cycle completion pulse, then back to IDLE

module sc_bitstream_gen #(
    parameter int RWID = 8,
    parameter int RWL2 = $clog2(RWID)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [RWID-1:0] in_data_i,
    input  logic [RWID:0]   in_len_i,
    output logic            rng_en_o,
    output logic [RWL2-1:0] rng_idx_o,
    input  logic [RWID-1:0] rng_val_i,
    output logic            bit_valid_o,
    input  logic            out_ready_i,
    output logic            bit_out_o,
    output logic            done_o,
    output logic [RWID:0]   ones_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RWID-1:0] src_q, src_d;
    logic [RWID:0]   len_q, len_d;
    logic [RWID:0]   bcnt_q, bcnt_d;
    // Free-running across streams so consecutive streams continue the sequence.
    logic [RWID-1:0] seq_q, seq_d;

`ifdef SC_BSGEN_ONES_CNT_EN
    localparam logic [RWID:0] ONES_MAX = {1'b1, {RWID{1'b0}}};
    logic [RWID:0]   ones_q, ones_d;
`endif

    // Index of the least-significant zero in seq; all-ones maps to RWID-1.
    always_comb begin
        rng_idx_o = RWL2'(RWID - 1);
        for (int i = RWID - 1; i >= 0; i--) begin
            if (!seq_q[i]) begin
                rng_idx_o = RWL2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        len_d       = len_q;
        bcnt_d      = bcnt_q;
        seq_d       = seq_q;
`ifdef SC_BSGEN_ONES_CNT_EN
        ones_d      = ones_q;
`endif
        in_ready_o  = 1'b0;
        bit_valid_o = 1'b0;
        done_o      = 1'b0;
        rng_en_o    = 1'b0;
        bit_out_o   = (src_q > rng_val_i);

        unique case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    src_d   = in_data_i;
                    len_d   = in_len_i;
                    bcnt_d  = '0;
`ifdef SC_BSGEN_ONES_CNT_EN
                    ones_d  = '0;
`endif
                    state_d = (in_len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                bit_valid_o = 1'b1;
                if (out_ready_i) begin
                    rng_en_o = 1'b1;
                    bcnt_d   = bcnt_q + 1'b1;
                    seq_d    = seq_q + 1'b1;
`ifdef SC_BSGEN_ONES_CNT_EN
                    if (bit_out_o && (ones_q != ONES_MAX)) begin
                        ones_d = ones_q + 1'b1;
                    end
`endif
                    if ((bcnt_q + 1'b1) == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            seq_q   <= seq_d;
        end
    end

`ifdef SC_BSGEN_ONES_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones_cnt_o = ones_q;
`else
    assign ones_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// Self-checking bench for sc_bitstream_gen with an 8-bit Sobol RNG model
// (first dimension, dirVec[i] = 0x80 >> i) attached to rng_en/rng_idx.

module tb_sc_bitstream_gen;

    localparam int RWID = 8;
    localparam int RWL2 = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [RWID-1:0] in_data;
    logic [RWID:0]   in_len;
    logic            rng_en;
    logic [RWL2-1:0] rng_idx;
    logic [RWID-1:0] rng_val;
    logic            bit_valid;
    logic            out_ready;
    logic            bit_out;
    logic            done;
    logic [RWID:0]   ones_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sc_bitstream_gen #(.RWID(RWID), .RWL2(RWL2)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_len_i    (in_len),
        .rng_en_o    (rng_en),
        .rng_idx_o   (rng_idx),
        .rng_val_i   (rng_val),
        .bit_valid_o (bit_valid),
        .out_ready_i (out_ready),
        .bit_out_o   (bit_out),
        .done_o      (done),
        .ones_cnt_o  (ones_cnt)
    );

    function automatic logic [7:0] dirv(input int idx);
        logic [7:0] v;
        v = 8'h80;
        return v >> idx;
    endfunction

    // External RNG, reset by the same net as the DUT.
    logic [7:0] rng_q;
    always @(posedge clk) begin
        if (!rst_n)      rng_q <= 8'h00;
        else if (rng_en) rng_q <= rng_q ^ dirv(int'(rng_idx));
    end
    assign rng_val = rng_q;

    // Reference model state, independent of the DUT outputs.
    logic [7:0] m_seq = 8'h00;
    logic [7:0] m_rng = 8'h00;
    bit         exp_bit[$];
    int         exp_idx[$];

    function automatic int lsz(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (!s[i]) return i;
        return 7;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic run_stream(input logic [7:0] data, input int len, input bit toggle,
                              input int rst_at, output int ones_obs);
        int  cyc, xfers, idx, exp_ones;
        bit  fin, stall_seen, stall_bit, b;
        ones_obs = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        in_len    = 9'(len);
        out_ready = 1'b0;
        #1;
        chk_eq("accept_ready", in_ready, 1);

        exp_ones = 0;
        for (int k = 0; k < len; k++) begin
            idx = lsz(m_seq);
            b   = (data > m_rng);
            exp_bit.push_back(b);
            exp_idx.push_back(idx);
            if (b) exp_ones++;
            m_rng = m_rng ^ dirv(idx);
            m_seq = m_seq + 8'd1;
        end

        cyc = 0; xfers = 0; fin = 0; stall_seen = 0; stall_bit = 0;
        while (!fin && cyc < 4 * len + 10) begin
            @(negedge clk);
            cyc++;
            if (rst_at >= 0 && xfers == rst_at) begin
                rst_n     = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                m_seq = 8'h00;
                m_rng = 8'h00;
                exp_bit.delete();
                exp_idx.delete();
                #1;
                chk_eq("rst_bit_valid", bit_valid, 0);
                chk_eq("rst_in_ready", in_ready, 1);
                chk_eq("rst_ones_cnt", ones_cnt, 0);
                chk_eq("rst_rng_idx", rng_idx, 0);
                chk_eq("rst_done", done, 0);
                chk_eq("rst_rng_en", rng_en, 0);
                return;
            end
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            // Requests while busy must be ignored.
            in_valid  = toggle;
            in_data   = 8'h5A;
            in_len    = 9'd3;
            #1;
            chk_eq("busy_in_ready", in_ready, 0);
            if (bit_valid) begin
                if (stall_seen) chk_eq("stall_stable", bit_out, stall_bit);
                stall_seen = 0;
                if (out_ready) begin
                    chk_eq("rng_en_xfer", rng_en, 1);
                    if (exp_bit.size() == 0) begin
                        chk_eq("extra_bit", 1, 0);
                    end else begin
                        chk_eq("bit_out", bit_out, exp_bit.pop_front());
                        chk_eq("rng_idx", rng_idx, exp_idx.pop_front());
                    end
                    xfers++;
                    if (bit_out) ones_obs++;
                end else begin
                    chk_eq("rng_en_stall", rng_en, 0);
                    stall_seen = 1;
                    stall_bit  = bit_out;
                end
            end else begin
                chk_eq("rng_en_idle", rng_en, 0);
            end
            if (done) begin
                fin      = 1;
                in_valid = 1'b0;
                chk_eq("xfer_count", xfers, len);
                chk_eq("ones_observed", ones_obs, exp_ones);
                if (!toggle) chk_eq("done_cycle", cyc, len + 1);
`ifdef SC_BSGEN_ONES_CNT_EN
                chk_eq("ones_cnt", ones_cnt, exp_ones);
`else
                chk_eq("ones_cnt", ones_cnt, 0);
`endif
            end
        end
        if (!fin) chk_eq("timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int ones;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_len    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("reset_in_ready", in_ready, 1);
        chk_eq("reset_bit_valid", bit_valid, 0);
        chk_eq("reset_done", done, 0);
        chk_eq("reset_rng_en", rng_en, 0);
        chk_eq("reset_ones_cnt", ones_cnt, 0);
        chk_eq("reset_rng_idx", rng_idx, 0);

        // Full-length stream at half scale.
        run_stream(8'h80, 256, 1'b0, -1, ones);
        chk_eq("half_ones", ones, 128);
        @(negedge clk); #1;
`ifdef SC_BSGEN_ONES_CNT_EN
        chk_eq("ones_hold", ones_cnt, 128);
`else
        chk_eq("ones_hold", ones_cnt, 0);
`endif

        // Zero-length stream.
        run_stream(8'h33, 0, 1'b0, -1, ones);

        // Backpressure toggling.
        run_stream(8'h40, 16, 1'b1, -1, ones);

        // Back-to-back streams continue the Gray sequence.
        run_stream(8'hC3, 4, 1'b0, -1, ones);
        run_stream(8'h21, 4, 1'b0, -1, ones);

        // Reset mid-stream.
        run_stream(8'h99, 16, 1'b0, 3, ones);

        // Full-scale source.
        run_stream(8'hFF, 256, 1'b0, -1, ones);
        chk_eq("full_ones", ones, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
